// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler
// Latches floor-button presses into a pending bitmap and picks the next target
// floor with a SCAN (sweep) policy. A request is dropped once the controller
// reports the door open at that floor. All outputs come straight from registers.

module elevator_request_scheduler #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  req_in,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               door_open,
  output logic [FLOORS-1:0]  pending,
  output logic [FLOOR_W-1:0] target,
  output logic               target_valid,
  output logic [1:0]         sweep
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } sweep_t;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  sweep_t             state;
  sweep_t             state_nxt;
  logic [FLOORS-1:0]  sync1;
  logic [FLOORS-1:0]  sync2;
  logic [FLOORS-1:0]  sync3;
  logic [FLOORS-1:0]  rise;
  logic [FLOORS-1:0]  clr_mask;
  logic [FLOORS-1:0]  pending_nxt;
  logic [FLOOR_W-1:0] cur;
  logic [FLOOR_W-1:0] low_above;
  logic [FLOOR_W-1:0] high_below;
  logic [FLOOR_W-1:0] dist_up;
  logic [FLOOR_W-1:0] dist_dn;
  logic [FLOOR_W-1:0] target_nxt;
  logic               above;
  logic               below;
  logic               here;

  // Out-of-range floor numbers from the controller are treated as the top floor.
  assign cur = (cur_floor > TOP_FLOOR) ? TOP_FLOOR : cur_floor;

  // Two-flop synchronizer plus a third flop that remembers the previous level,
  // so only a fresh 0->1 press produces a one-cycle rise pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= req_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  // Apply this cycle's presses and the door-open clear; the clear is applied
  // last so a press at the floor whose door is open is simply ignored.
  always_comb begin
    clr_mask = '0;
    if (door_open) clr_mask[cur] = 1'b1;
    pending_nxt = (pending | rise) & ~clr_mask;
  end

  // Find the nearest pending floor on each side of the car.
  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    low_above  = '0;
    high_below = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending_nxt[i] && (FLOOR_W'(i) > cur)) begin
        above     = 1'b1;
        low_above = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (pending_nxt[i] && (FLOOR_W'(i) < cur)) begin
        below      = 1'b1;
        high_below = FLOOR_W'(i);
      end
    end
    here = pending_nxt[cur];
  end

  assign dist_up = low_above - cur;
  assign dist_dn = cur - high_below;

  // Sweep decision: keep going while work remains ahead, otherwise turn round
  // or rest; from rest head for the nearer side, preferring up on a tie.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (above && !below)      state_nxt = UP;
        else if (below && !above) state_nxt = DOWN;
        else if (above && below)  state_nxt = (dist_up <= dist_dn) ? UP : DOWN;
        else                      state_nxt = IDLE;
      end
      UP: begin
        if (above)      state_nxt = UP;
        else if (below) state_nxt = DOWN;
        else            state_nxt = IDLE;
      end
      DOWN: begin
        if (below)      state_nxt = DOWN;
        else if (above) state_nxt = UP;
        else            state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    target_nxt = target;
    case (state_nxt)
      UP:      target_nxt = low_above;
      DOWN:    target_nxt = high_below;
      default: if (here) target_nxt = cur;
    endcase
  end

  // Register the request bitmap, sweep state and target together so all
  // outputs change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= '0;
      state        <= IDLE;
      target       <= '0;
      target_valid <= 1'b0;
    end else begin
      pending      <= pending_nxt;
      state        <= state_nxt;
      target       <= target_nxt;
      target_valid <= |pending_nxt;
    end
  end

  assign sweep = state;

endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Upstream stage of the elevator controller. It captures floor-button presses into a pending-request bitmap and selects the next target floor using a SCAN (sweep) policy. It clears each request once the controller reports the door open at that floor. Inputs from the controller are its current floor (`y`) and door-open flag (`open`). The output is a registered target floor with a valid flag.

## Interface
Parameters:
- `FLOORS`, 8: number of floors; bit 0 is Ground.
- `FLOOR_W`, 3: width of floor index; 2^FLOOR_W ≥ FLOORS.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `req_in`  in  FLOORS  raw level button inputs; bit i = floor i (bit0 = inG … bit7 = in7); asynchronous to `clk`.
- `cur_floor`  in  FLOOR_W  current floor from controller `y`.
- `door_open`  in  1  controller `open` flag.
- `pending`  out  FLOORS  latched outstanding requests.
- `target`  out  FLOOR_W  next floor to serve.
- `target_valid`  out  1  `target` meaningful (pending nonzero).
- `sweep`  out  2  sweep state: 00 IDLE, 01 UP, 10 DOWN.

## Operation
- Input path, per bit: 2-flop synchronizer, then rising-edge detect against a third flop.
  - Only a 0→1 transition latches a request.
  - A button held high never re-latches.
  - Synchronizer flops reset to 0, so a button held high through reset release latches once.
- Set/clear of `pending[i]`:
  - Set on a synchronized rising edge.
  - Clear when `door_open`=1 and `cur_floor`=i.
  - Both in the same cycle at the same floor: clear wins, so a press at an open-door floor is ignored.
  - Set at floor i and clear at floor j≠i in the same cycle: both take effect.
- Derived each cycle from `pending` (after this cycle's set/clear) and `cur_floor`:
  - `above` = any pending > cur_floor.
  - `below` = any pending < cur_floor.
  - `here` = pending[cur_floor].
- FSM transitions:
  - IDLE:
    - `above`&!`below` → UP.
    - `below`&!`above` → DOWN.
    - `above`&`below`: go toward the nearer floor of the two (lowest above vs highest below); equal distance → UP.
    - Only `here`, or empty: stay IDLE.
  - UP: stay while `above`; else if `below` → DOWN; else → IDLE.
  - DOWN: stay while `below`; else if `above` → UP; else → IDLE.
- Target selection, using the next state:
  - UP: lowest pending floor > cur_floor.
  - DOWN: highest pending floor < cur_floor.
  - IDLE with `here`: target = cur_floor.
  - IDLE with empty pending: target holds its last value, target_valid=0.
- `target_valid` = (next pending ≠ 0).
- Floor indices ≥ FLOORS on `cur_floor` are treated as FLOORS-1 (saturate).
- Reset values: pending=0, target=0, target_valid=0, sweep=00 (IDLE), synchronizer/edge flops=0.

## Timing
- All state registered on the rising edge of `clk`; outputs are direct register outputs with no combinational path from inputs.
- Press latency: `req_in[i]` rises before edge N; sync1 at N, sync2 at N+1, edge flop compare at N+2.
  - `pending[i]` goes high after edge N+2.
  - `target`/`target_valid`/`sweep` update on that same edge.
  - `target`, `target_valid` and `sweep` are computed from next-pending, so press to target_valid is 3 cycles.
- Clear latency: `door_open`=1 and `cur_floor`=i sampled at edge M; `pending[i]`=0 and the new target are visible after edge M.
- Minimum press width for capture: 2 `clk` periods high; narrower pulses may be missed.
- Reset asserted at any time: all outputs reach reset values immediately (asynchronously), regardless of FSM state. Deassertion is expected synchronous to `clk` at the system level.

## Test plan
- Reset then idle: `rst`=0 for 1 cycle, then `rst`=1 with no input → pending=00000000, target_valid=0, sweep=00, stable for 20 cycles.
- Single press upward:
  - Stimulus: cur_floor=0, pulse req_in[7] high for 5 cycles.
  - pending=10000000 exactly 3 edges after the rise; target=7, target_valid=1, sweep=01.
  - Pulse req_in[7] again while held: no change.
- Sweep ordering:
  - Stimulus: cur_floor=2, pending floors 1, 5, 6 latched.
  - IDLE tie-break: floor 1 is distance 1, floor 5 is distance 3, so sweep=10 and target=1.
  - Then door_open at floor 1 → pending=01100000, sweep=01, target=5.
  - Then cur_floor=5 with door_open → target=6.
- Press at open-door floor: cur_floor=3, door_open=1, press req_in[3] → pending[3] stays 0. Press req_in[4] in the same window → pending[4]=1, target=4.
- Simultaneous set/clear: cur_floor=2 with door_open asserted in the same cycle as req_in[0]'s edge, pending[2]=1 → pending[2] clears, pending[0] sets, sweep=10, target=0.
- Reset mid-sweep: sweep=01 with pending=00110000, `rst` driven low asynchronously between edges → pending=0, target=0, target_valid=0, sweep=00 before the next edge. Held req_in[4] re-latches 3 edges after `rst`=1.
